// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-requester image RAM arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_state_e;

  localparam int REQ_CORE   = 0;
  localparam int REQ_IO     = 1;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  function automatic logic [1:0] req_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dram_arb_if.sv
// Bundle of both requester ports and the single RAM port seen by the arbiter.
interface dram_arb_if
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Handshake: a requester raises req with stable we/lock/addr/wdata and holds
  // them until gnt; the transaction transfers in the cycle where req && gnt.
  logic              p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_din, mem_dout;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  mem_dout,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_read, mem_write, mem_din
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output mem_dout,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_read, mem_write, mem_din
  );

endinterface

// File: rtl/dram_arb_pick.sv
// Combinational grant selection from requests, owner state and round-robin pointer.
module dram_arb_pick
  import dram_arb_pkg::*;
(
  input  logic [1:0]   req_i,
  input  owner_state_e state_i,
  input  logic         rr_ptr_i,
  output logic [1:0]   gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (state_i)
      // An owner keeps exclusive eligibility even on cycles it does not request.
      OWN0: gnt_o[REQ_CORE] = req_i[REQ_CORE];
      OWN1: gnt_o[REQ_IO]   = req_i[REQ_IO];
      default: begin
        case (req_i)
          2'b01:   gnt_o = 2'b01;
          2'b10:   gnt_o = 2'b10;
          2'b11:   gnt_o = req_onehot(rr_ptr_i);
          default: gnt_o = 2'b00;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter with bounded locked bursts in front of the single-port image RAM.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int  ADDR_W    = DEF_ADDR_W,
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  BURST_MAX = 16,
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  dram_arb_if.slave        bus,
  output owner_state_e     state_o,
  output logic             rr_ptr_o,
  output logic [CNT_W-1:0] burst_cnt_o
);

  owner_state_e      state_q, state_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        req, pick_gnt, gnt;
  logic              any_gnt, sel, sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {bus.p1_req, bus.p0_req};

  dram_arb_pick u_pick (
    .req_i   (req),
    .state_i (state_q),
    .rr_ptr_i(rr_q),
    .gnt_o   (pick_gnt)
  );

  // Grants are masked while reset is held so the RAM sees no strobes.
  assign gnt     = rst ? 2'b00 : pick_gnt;
  assign any_gnt = |gnt;
  assign sel     = gnt[REQ_IO];

  always_comb begin
    sel_we    = bus.p0_we;
    sel_lock  = bus.p0_lock;
    sel_addr  = bus.p0_addr;
    sel_wdata = bus.p0_wdata;
    if (sel) begin
      sel_we    = bus.p1_we;
      sel_lock  = bus.p1_lock;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end
  end

  assign bus.p0_gnt    = gnt[REQ_CORE];
  assign bus.p1_gnt    = gnt[REQ_IO];
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_din   = sel_wdata;
  assign bus.mem_read  = any_gnt & ~sel_we;
  assign bus.mem_write = any_gnt & sel_we;
  assign bus.p0_rdata  = bus.mem_dout;
  assign bus.p1_rdata  = bus.mem_dout;
  assign bus.p0_rvalid = rvalid_q[REQ_CORE];
  assign bus.p1_rvalid = rvalid_q[REQ_IO];

  assign cnt_inc  = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  assign rvalid_d = gnt & ~{bus.p1_we, bus.p0_we};

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (any_gnt) begin
      // The BURST_MAX-th consecutive grant always hands the pointer to the other side.
      if (sel_lock && (cnt_inc != CNT_W'(BURST_MAX))) begin
        state_d = sel ? OWN1 : OWN0;
        cnt_d   = cnt_inc;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        rr_d    = ~sel;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      rr_d    = (state_q == OWN0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign state_o     = state_q;
  assign rr_ptr_o    = rr_q;
  assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int CW = $clog2(BM + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  owner_state_e state_dbg;
  logic         rr_dbg;
  logic [CW-1:0] cnt_dbg;
  int n_tests = 0;
  int n_fail  = 0;

  dram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .state_o    (state_dbg),
    .rr_ptr_o   (rr_dbg),
    .burst_cnt_o(cnt_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM environment ----------------
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  logic [DW-1:0] ram [0:65535];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(16'(i));
      ram_loaded <= 1'b1;
    end else begin
      if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_din;
      if (bus.mem_read)  bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [int];
  int m_owner, m_pref, m_run, exp_g;
  logic          cur_req[2], cur_we[2], cur_lock[2];
  logic [AW-1:0] cur_addr[2];
  logic [DW-1:0] cur_wdata[2];
  logic          exp_rv[2];
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(a);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_pref = 0; m_run = 0; exp_g = -1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    cur_req[0] = r0; cur_we[0] = w0; cur_lock[0] = l0; cur_addr[0] = a0; cur_wdata[0] = d0;
    cur_req[1] = r1; cur_we[1] = w1; cur_lock[1] = l1; cur_addr[1] = a1; cur_wdata[1] = d1;
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_lock = l0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_lock = l1; bus.p1_addr = a1; bus.p1_wdata = d1;
    #1;
    if (m_owner >= 0)      exp_g = cur_req[m_owner] ? m_owner : -1;
    else if (r0 && r1)     exp_g = m_pref;
    else if (r0)           exp_g = 0;
    else if (r1)           exp_g = 1;
    else                   exp_g = -1;
  endtask

  task automatic idle_in();
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) exp_rv[k] = (exp_g == k) && !cur_we[k];
    if (exp_g >= 0) begin
      if (cur_we[exp_g]) ref_mem[int'(cur_addr[exp_g])] = cur_wdata[exp_g];
      else exp_q.push_back(ref_rd(cur_addr[exp_g]));
      m_run++;
      if (cur_lock[exp_g] && m_run < BM) m_owner = exp_g;
      else begin m_owner = -1; m_run = 0; m_pref = 1 - exp_g; end
    end else if (m_owner >= 0) begin
      m_pref = 1 - m_owner; m_owner = -1; m_run = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h11);
    @(posedge clk); @(negedge clk); #1;
    n_tests++; if (bus.p0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %b exp 0", bus.p0_gnt); end
    n_tests++; if (bus.p1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1: got %b exp 0", bus.p1_gnt); end
    n_tests++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %b exp 0", bus.mem_read); end
    n_tests++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b exp 0", bus.mem_write); end
    n_tests++; if ({bus.p1_rvalid, bus.p0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 00", {bus.p1_rvalid, bus.p0_rvalid}); end
    n_tests++; if (state_dbg !== IDLE || rr_dbg !== 1'b0 || cnt_dbg !== '0) begin n_fail++; $display("FAIL rst_state: got st=%0d rr=%b cnt=%0d exp 0/0/0", state_dbg, rr_dbg, cnt_dbg); end
    model_reset();
    idle_in();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hA5);
    n_tests++; if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) begin n_fail++; $display("FAIL sr_wr_gnt: got %b%b exp 10", bus.p1_gnt, bus.p0_gnt); end
    n_tests++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL sr_wr_mem: got we=%b a=%h d=%h exp 1/0010/a5", bus.mem_write, bus.mem_addr, bus.mem_din); end
    tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0010, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (bus.p0_gnt !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL sr_rd_issue: got g=%b rd=%b a=%h exp 1/1/0010", bus.p0_gnt, bus.mem_read, bus.mem_addr); end
    n_tests++; if (bus.p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_wr_no_resp: got %b exp 0", bus.p1_rvalid); end
    tick();
    idle_in();
    n_tests++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'hA5) begin n_fail++; $display("FAIL sr_rdata: got v=%b d=%h exp 1/a5", bus.p0_rvalid, bus.p0_rdata); end
    tick();
    idle_in();
    n_tests++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_rvalid_pulse: got %b exp 0", bus.p0_rvalid); end
  endtask

  task automatic test_write_read_order();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h3C);
    tick();
    apply(1'b1, 1'b0, 1'b0, 16'hFFFF, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_ord_gnt: got %b exp 1", bus.p0_gnt); end
    tick();
    idle_in();
    n_tests++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'h3C) begin n_fail++; $display("FAIL wr_ord_rdata: got v=%b d=%h exp 1/3c", bus.p0_rvalid, bus.p0_rdata); end
  endtask

  task automatic test_contention();
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 16'(i), '0, 1'b1, 1'b0, 1'b0, 16'(16'h0100 + i), '0);
      n_tests++; if (bus.p0_gnt !== (i % 2 == 0) || bus.p1_gnt !== (i % 2 == 1)) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b%b exp p%0d", i, bus.p1_gnt, bus.p0_gnt, i % 2); end
      n_tests++; if (rr_dbg !== (i % 2 == 1)) begin n_fail++; $display("FAIL cont_rr[%0d]: got %b exp %0d", i, rr_dbg, i % 2); end
      if (i > 0) begin
        e = exp_q.pop_front();
        n_tests++; if (bus.p0_rvalid !== (i % 2 == 1) || bus.p1_rvalid !== (i % 2 == 0) || bus.mem_dout !== e) begin n_fail++; $display("FAIL cont_rd[%0d]: got v=%b%b d=%h exp d=%h", i, bus.p1_rvalid, bus.p0_rvalid, bus.mem_dout, e); end
      end
      tick();
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 16'h0001, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0002, '0, 1'b1, 1'b0, 1'b1, 16'(16'h0200 + i), '0);
      n_tests++; if (bus.p1_gnt !== (i < 4) || bus.p0_gnt !== (i == 4)) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b%b exp %s", i, bus.p1_gnt, bus.p0_gnt, (i < 4) ? "p1" : "p0"); end
      n_tests++; if (state_dbg !== ((i >= 1 && i <= 3) ? OWN1 : IDLE) || cnt_dbg !== CW'((i >= 1 && i <= 3) ? i : 0)) begin n_fail++; $display("FAIL burst_state[%0d]: got st=%0d cnt=%0d", i, state_dbg, cnt_dbg); end
      n_tests++; if (rr_dbg !== (i < 4)) begin n_fail++; $display("FAIL burst_rr[%0d]: got %b exp %b", i, rr_dbg, (i < 4)); end
      tick();
    end
  endtask

  task automatic test_req_drop();
    logic [1:0] pat_g [4];
    logic       pat_r0 [4];
    pat_g  = '{2'b01, 2'b01, 2'b00, 2'b10};
    pat_r0 = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(pat_r0[i], 1'b1, 1'b1, 16'h0300, 8'(i), 1'b1, 1'b1, 1'b0, 16'h0301, 8'h77);
      n_tests++; if ({bus.p1_gnt, bus.p0_gnt} !== pat_g[i]) begin n_fail++; $display("FAIL drop_gnt[%0d]: got %b%b exp %b", i, bus.p1_gnt, bus.p0_gnt, pat_g[i]); end
      if (i == 3) begin
        n_tests++; if (state_dbg !== IDLE || rr_dbg !== 1'b1) begin n_fail++; $display("FAIL drop_state: got st=%0d rr=%b exp IDLE/1", state_dbg, rr_dbg); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 16'h1234, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    n_tests++; if (bus.p0_rvalid !== 1'b1 || rr_dbg !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got v=%b rr=%b exp 1/1", bus.p0_rvalid, rr_dbg); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid_async: got %b exp 0", bus.p0_rvalid); end
    n_tests++; if (bus.p0_gnt !== 1'b0 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL mid_gnt_in_rst: got g=%b rd=%b exp 0/0", bus.p0_gnt, bus.mem_read); end
    @(posedge clk); @(negedge clk);
    model_reset();
    idle_in();
    rst = 1'b0;
    #1;
    n_tests++; if (state_dbg !== IDLE || rr_dbg !== 1'b0 || bus.p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_post: got st=%0d rr=%b v=%b exp IDLE/0/0", state_dbg, rr_dbg, bus.p0_rvalid); end
    tick();
    idle_in();
    n_tests++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got %b exp 0", bus.p0_rvalid); end
  endtask

  task automatic test_random();
    logic          pend[2], t_we[2], lk[2];
    logic [AW-1:0] t_addr[2];
    logic [DW-1:0] t_data[2], e;
    int            wait_c[2];
    logic          g;
    owner_state_e  es;
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0; wait_c[0] = 0; wait_c[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k]   = 1'b1;
          t_we[k]   = ($urandom_range(0, 2) == 0);
          t_addr[k] = 16'hFFF0 | 16'($urandom_range(0, 15));
          t_data[k] = 8'($urandom);
        end
        lk[k] = ($urandom_range(0, 3) != 0);
      end
      apply(pend[0], t_we[0], lk[0], t_addr[0], t_data[0], pend[1], t_we[1], lk[1], t_addr[1], t_data[1]);
      n_tests++; if (bus.p0_gnt !== (exp_g == 0) || bus.p1_gnt !== (exp_g == 1)) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b%b exp id %0d", c, bus.p1_gnt, bus.p0_gnt, exp_g); end
      n_tests++; if (bus.mem_read !== (exp_g >= 0 && !cur_we[exp_g >= 0 ? exp_g : 0]) || bus.mem_write !== (exp_g >= 0 && cur_we[exp_g >= 0 ? exp_g : 0])) begin n_fail++; $display("FAIL rnd_strobe[%0d]: got rd=%b wr=%b exp id %0d", c, bus.mem_read, bus.mem_write, exp_g); end
      if (exp_g >= 0) begin
        n_tests++; if (bus.mem_addr !== cur_addr[exp_g] || (cur_we[exp_g] && bus.mem_din !== cur_wdata[exp_g])) begin n_fail++; $display("FAIL rnd_mem[%0d]: got a=%h d=%h exp a=%h d=%h", c, bus.mem_addr, bus.mem_din, cur_addr[exp_g], cur_wdata[exp_g]); end
      end
      n_tests++; if (bus.p0_rvalid !== exp_rv[0] || bus.p1_rvalid !== exp_rv[1]) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b%b exp %b%b", c, bus.p1_rvalid, bus.p0_rvalid, exp_rv[1], exp_rv[0]); end
      if (exp_rv[0] || exp_rv[1]) begin
        e = exp_q.pop_front();
        n_tests++; if ((exp_rv[0] ? bus.p0_rdata : bus.p1_rdata) !== e) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", c, exp_rv[0] ? bus.p0_rdata : bus.p1_rdata, e); end
      end
      es = (m_owner < 0) ? IDLE : ((m_owner == 0) ? OWN0 : OWN1);
      n_tests++; if (state_dbg !== es || rr_dbg !== (m_pref == 1) || cnt_dbg !== CW'(m_run)) begin n_fail++; $display("FAIL rnd_state[%0d]: got st=%0d rr=%b cnt=%0d exp st=%0d rr=%0d cnt=%0d", c, state_dbg, rr_dbg, cnt_dbg, es, m_pref, m_run); end
      for (int k = 0; k < 2; k++) begin
        g = (k == 0) ? bus.p0_gnt : bus.p1_gnt;
        if (pend[k] && !g) wait_c[k]++; else wait_c[k] = 0;
        if (pend[k]) begin
          n_tests++; if (wait_c[k] > BM + 1) begin n_fail++; $display("FAIL rnd_starve[%0d] p%0d: waited %0d limit %0d", c, k, wait_c[k], BM + 1); end
        end
      end
      if (exp_g >= 0) pend[exp_g] = 1'b0;
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_write_read_order();
    test_contention();
    test_locked_burst();
    test_req_drop();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
